// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver:
// FSM states, data-width codes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int MIN_DIV = 2;

    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic [1:0] width,
        input logic       odd
    );
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - width);
        return (^(data & mask)) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// Writes when full are dropped; occupancy exposed as count_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter: FIFO-fed frame serialiser with runtime frame
// format, baud divisor and line-break generation.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             odd_n_even,
    input  logic             two_stop,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             break_req,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             ovf
);

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, reload;
    logic [7:0]       shift_q, shift_d, fifo_rdata;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       dbits_q, dbits_d;
    logic             par_en_q, par_en_d, par_q, par_d;
    logic             two_q, two_d, brk_q, brk_d;
    logic             tx_q, tx_d, done_q, done_d, ovf_q;
    logic             pop, bit_end, last_bit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign reload = (baud_div < DIV_W'(MIN_DIV))
                  ? DIV_W'(MIN_DIV - 1)
                  : baud_div - DIV_W'(1);

    assign bit_end  = (cnt_q == '0);
    assign last_bit = (bit_q == 3'd4 + {1'b0, dbits_q});

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? div_q : cnt_q - DIV_W'(1);
        div_d    = div_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        dbits_d  = dbits_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        two_d    = two_q;
        brk_d    = brk_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        tx_d     = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (break_req) begin
                    state_d = S_BREAK;
                    cnt_d   = reload;
                    div_d   = reload;
                    brk_d   = 1'b1;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    cnt_d    = reload;
                    div_d    = reload;
                    shift_d  = fifo_rdata;
                    dbits_d  = data_bits;
                    par_en_d = parity_en;
                    par_d    = parity_bit(fifo_rdata, data_bits, odd_n_even);
                    two_d    = two_stop;
                    brk_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    if (two_q && !brk_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = !brk_q;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_BREAK: begin
                // Timer parks at zero once the minimum bit time has elapsed.
                if (bit_end) begin
                    cnt_d = cnt_q;
                    if (!break_req) begin
                        state_d = S_STOP1;
                        cnt_d   = div_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            dbits_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            two_q    <= 1'b0;
            brk_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            dbits_q  <= dbits_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            two_q    <= two_d;
            brk_q    <= brk_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ovf_q    <= wr_en & fifo_full;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != S_IDLE);
    assign tx_done = done_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised UART transmitter with an internal transmit FIFO. It is the synthesizable successor to the fixed 11-bit frame stimulus used in our SoC benches. The block serialises queued bytes with a runtime-selectable data width (5–8), parity (none/even/odd), 1 or 2 stop bits and baud divisor, and can also send a line break. It sits on the SoC peripheral bus next to the UART receiver, and doubles as a bench frame generator.

Parameters:
FIFO_DEPTH, 16, transmit FIFO entries; must be a power of 2 and at least 2.
DIV_W, 16, width of the baud divisor.
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  push wr_data into the FIFO
wr_data  in  8  byte to send; bits above the data width are ignored
data_bits  in  2  data width: 00=5, 01=6, 10=7, 11=8
parity_en  in  1  1 = append a parity bit
odd_n_even  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = two stop bits
baud_div  in  DIV_W  clocks per bit; values below 2 are treated as 2
break_req  in  1  level request to hold the line low (break)
tx  out  1  serial line, idle high
busy  out  1  FSM is not in IDLE
tx_done  out  1  one-cycle pulse at the end of the last stop bit
fifo_full  out  1  FIFO is full
fifo_empty  out  1  FIFO is empty
fifo_count  out  CNT_W  current FIFO occupancy
ovf  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (asynchronous, active-high): tx=1, busy=0, tx_done=0, ovf=0, fifo_empty=1, fifo_full=0, fifo_count=0. FIFO pointers are cleared. Reset mid-frame aborts the frame immediately, with no glitch low.
- FIFO: synchronous first-in first-out.
  - A write when full is dropped and ovf pulses in the following cycle.
  - A write and a pop in the same cycle leave the count unchanged.
  - A write to an empty FIFO is visible (fifo_empty=0) in the next cycle.
- Baud timer: a DIV_W-bit down-counter loaded with max(baud_div,2)-1 at the start of each bit. Each bit lasts exactly max(baud_div,2) clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE:
  - If break_req=1, go to BREAK. Break has priority over FIFO data.
  - Else if the FIFO is not empty: pop the FIFO; latch the byte, data_bits, parity_en, odd_n_even, two_stop and baud_div; go to START. tx goes low in the cycle after the pop.
  - Config changes mid-frame take effect only on the next frame.
- START: tx=0 for one bit time, then DATA.
- DATA: sends data_bits+5 bits, LSB first, one bit time each. Then PARITY if parity_en, else STOP1.
- PARITY: bit = XOR of the sent data bits, inverted when odd_n_even=1.
- STOP1: tx=1 for one bit time. Then STOP2 if two_stop, else IDLE with tx_done pulsed.
- STOP2: tx=1 for one bit time, then IDLE with tx_done pulsed.
- BREAK: tx=0 while break_req=1, for a minimum of one bit time. After release, go to STOP1 (one bit time of mark). tx_done is not pulsed after a break.
- Back-to-back frames: when the FIFO is non-empty at the end of a stop bit, the next start bit begins after exactly one IDLE cycle.
- busy is high in every state except IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum;
  - data-width codes DBITS_5..DBITS_8;
  - constant MIN_DIV=2;
  - a function that returns parity from (data, width, odd).
- One sub-module, sync_fifo (parameters WIDTH=8, DEPTH). It provides full, empty and count, and is reused by the receiver.

Test Plan:
- 8N1, baud_div=10, write 0x41 -> tx after the pop cycle is 0,1,0,0,0,0,0,1,0,1, each bit 10 clocks; frame 100 clocks; tx_done pulses once; busy high throughout.
- 8O1, baud_div=10, 0x41 -> parity bit = 1 (0x41 has two ones); 11 bits = 110 clocks. With odd_n_even=0 the parity bit = 0.
- 7E2, baud_div=4, 0xC1 -> data bits 1,0,0,0,0,0,1 (bit 7 ignored); parity 0; two stop bits; 11 bits = 44 clocks.
- Overflow, FIFO_DEPTH=16, baud_div=100: 18 back-to-back writes -> byte 0 enters the shifter, fifo_count=16, the 18th write is dropped, ovf pulses once; exactly 17 frames emerge in order.
- Break/limits: break_req high for 50 clocks with baud_div=10 -> tx low 50 clocks, then high ≥10 clocks. baud_div=0 -> every bit lasts 2 clocks.
- Reset mid-data-bit of a 0x00 frame -> tx=1 within the same cycle; FIFO empty; after release, no residual frame is sent.
